onset_bpm_tracker: RTL and testbench



---
 rtl/onset_bpm_tracker.sv | 163 ++++++++++++++++
 tb/tb_onset_bpm_tracker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onset_bpm_tracker.sv
// Onset detector with refractory window, interval history and BPM estimate.
// Onsets are EMA-relative level jumps; BPM = 60000*DEPTH / sum(intervals) via a serial divider.
module onset_bpm_tracker #(
   parameter int W               = 16,
   parameter int CLK_FREQ        = 50_000_000,
   parameter int TICK_HZ         = 1000,
   parameter int ALPHA_SHIFT     = 4,
   parameter int THRESH_OFFSET   = 64,
   parameter int MIN_INTERVAL_MS = 250,
   parameter int MAX_INTERVAL_MS = 2000,
   parameter int DEPTH           = 8,
   parameter int LED_MS          = 100
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] sample_in,
   input  logic         sample_valid,
   output logic         onset_pulse,
   output logic         beat_led,
   output logic [9:0]   bpm,
   output logic         bpm_valid,
   output logic         busy
);
   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int PW  = $clog2(DIV) + 1;
   localparam int TW  = $clog2(MAX_INTERVAL_MS + 2);
   localparam int SW  = $clog2(DEPTH * MAX_INTERVAL_MS + 1);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = $clog2(LED_MS + 1);

   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   localparam logic [TW-1:0] T_MIN    = TW'(MIN_INTERVAL_MS);
   localparam logic [TW-1:0] T_MAX    = TW'(MAX_INTERVAL_MS);
   localparam logic [TW-1:0] T_TO     = TW'(MAX_INTERVAL_MS + 1);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [LW-1:0] LED_LOAD = LW'(LED_MS);
   localparam logic [23:0]   DIVIDEND = 24'(60000 * DEPTH);

   typedef enum logic {NO_REF, TRACKING} state_t;
   typedef enum logic [1:0] {D_IDLE, D_LOAD, D_ITER, D_WB} dstate_t;

   state_t  state;
   dstate_t dstate;

   logic [PW-1:0]       pre;
   logic                tick;
   logic [TW-1:0]       since;
   logic signed [W+1:0] ema, ema_diff;
   logic [W:0]          thresh;
   logic                cand, timeout, from_noref, in_window, accept, record, start;
   logic [TW-1:0]       hist [DEPTH];
   logic [SW-1:0]       sum, sum_new, old_entry;
   logic [CW-1:0]       count, count_new;
   logic [AW-1:0]       wr_ptr;
   logic [LW-1:0]       led_cnt;
   logic [SW-1:0]       divisor, rem;
   logic [SW:0]         rem_sh;
   logic                rem_ge;
   logic [23:0]         quo;
   logic [4:0]          iter;

   assign tick     = (pre == PRE_LAST);
   assign ema_diff = $signed({2'b00, sample_in}) - ema;
   // ema stays within [0, 2^W), so W+1 bits hold ema + offset without overflow
   assign thresh   = ema[W:0] + (W+1)'(THRESH_OFFSET);
   assign cand     = sample_valid && ({1'b0, sample_in} > thresh);

   // A timeout drops back to NO_REF first, so a same-cycle candidate is taken as a fresh reference
   assign timeout    = (state == TRACKING) && (since == T_TO);
   assign from_noref = (state == NO_REF) || timeout;
   assign in_window  = (since >= T_MIN) && (since <= T_MAX);
   assign accept     = cand && (from_noref || in_window);
   assign record     = accept && !from_noref;

   assign old_entry = (count == FULL) ? SW'(hist[wr_ptr]) : '0;
   assign sum_new   = sum - old_entry + SW'(since);
   assign count_new = (count == FULL) ? count : count + CW'(1);
   assign start     = record && (count_new == FULL);

   assign rem_sh   = {rem, quo[23]};
   assign rem_ge   = rem_sh >= {1'b0, divisor};
   assign beat_led = (led_cnt != '0);
   assign busy     = (dstate != D_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= NO_REF;
         dstate      <= D_IDLE;
         pre         <= '0;
         since       <= '0;
         ema         <= '0;
         sum         <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         led_cnt     <= '0;
         divisor     <= '0;
         rem         <= '0;
         quo         <= '0;
         iter        <= '0;
         onset_pulse <= 1'b0;
         bpm         <= '0;
         bpm_valid   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      end else begin
         pre         <= tick ? '0 : pre + PW'(1);
         onset_pulse <= accept;
         if (sample_valid) ema <= ema + (ema_diff >>> ALPHA_SHIFT);

         if (accept)                      since <= '0;
         else if (tick && since != T_TO) since <= since + TW'(1);

         if (accept)                        led_cnt <= LED_LOAD;
         else if (tick && led_cnt != '0)    led_cnt <= led_cnt - LW'(1);

         if (accept)       state <= TRACKING;
         else if (timeout) state <= NO_REF;

         if (timeout) begin
            count  <= '0;
            sum    <= '0;
            wr_ptr <= '0;
         end
         if (record) begin
            hist[wr_ptr] <= since;
            wr_ptr       <= wr_ptr + AW'(1);
            sum          <= sum_new;
            count        <= count_new;
         end

         // Restoring divider: load, 24 shift/subtract steps, writeback
         if (timeout) begin
            dstate    <= D_IDLE;
            bpm       <= '0;
            bpm_valid <= 1'b0;
         end else if (start) begin
            divisor <= sum_new;
            dstate  <= D_LOAD;
         end else begin
            case (dstate)
               D_LOAD: begin
                  rem    <= '0;
                  quo    <= DIVIDEND;
                  iter   <= '0;
                  dstate <= D_ITER;
               end
               D_ITER: begin
                  rem  <= rem_ge ? SW'(rem_sh - {1'b0, divisor}) : rem_sh[SW-1:0];
                  quo  <= {quo[22:0], rem_ge};
                  iter <= iter + 5'd1;
                  if (iter == 5'd23) dstate <= D_WB;
               end
               D_WB: begin
                  bpm       <= (quo > 24'd1023) ? 10'd1023 : quo[9:0];
                  bpm_valid <= 1'b1;
                  dstate    <= D_IDLE;
               end
               default: dstate <= D_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_onset_bpm_tracker.sv
// Scoreboard bench for onset_bpm_tracker: stimulus queues expected pulses, writebacks and
// cycle-stamped output snapshots; one monitor process compares them against the DUT.
module tb_onset_bpm_tracker;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        onset_pulse, beat_led, bpm_valid, busy;
   logic [9:0]  bpm;

   onset_bpm_tracker #(
      .W(16), .CLK_FREQ(1000), .TICK_HZ(1000), .ALPHA_SHIFT(4), .THRESH_OFFSET(64),
      .MIN_INTERVAL_MS(250), .MAX_INTERVAL_MS(2000), .DEPTH(4), .LED_MS(100)
   ) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .onset_pulse(onset_pulse), .beat_led(beat_led), .bpm(bpm), .bpm_valid(bpm_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // snapshot word: {onset_pulse, beat_led, busy, bpm_valid, bpm[9:0]}
   localparam int M_BPM   = 32'h3FF;
   localparam int M_VALID = 1 << 10;
   localparam int M_BUSY  = 1 << 11;
   localparam int M_LED   = 1 << 12;
   localparam int M_ALL   = 32'h3FFF;

   typedef struct { int cyc; int val; int mask; int tag; } snap_t;
   typedef struct { int cyc; int bpm; } wb_t;

   int    pulse_q[$];
   wb_t   wb_q[$];
   snap_t snap_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   bit    done = 1'b0;

   // reference model of the interval history
   bit m_trk = 1'b0;
   int m_iv[$];
   int m_bpm = 0;
   bit m_valid = 1'b0;

   task automatic add_snap(input int c, input int v, input int m, input int tag);
      snap_q.push_back('{c, v, m, tag});
   endtask

   task automatic step(input logic [15:0] s, input logic v);
      @(negedge clk);
      sample_in    = s;
      sample_valid = v;
   endtask

   task automatic gap(input int n);
      repeat (n) step(16'd0, 1'b1);
   endtask

   task automatic hit(input bit expect_pulse);
      step(16'd1000, 1'b1);
      if (expect_pulse) pulse_q.push_back(cyc + 1);
   endtask

   task automatic model_clear();
      m_trk = 1'b0;
      m_iv.delete();
      m_bpm = 0;
      m_valid = 1'b0;
   endtask

   // gap_n quiet cycles, then an impulse that should be accepted with interval iv
   task automatic beat_iv(input int gap_n, input int iv, input bit do_wb, input int tag);
      int k, s, b;
      gap(gap_n);
      hit(1'b1);
      k = cyc;
      if (m_trk) begin
         m_iv.push_back(iv);
         if (m_iv.size() > 4) void'(m_iv.pop_front());
         if (m_iv.size() == 4 && do_wb) begin
            s = 0;
            foreach (m_iv[i]) s += m_iv[i];
            b = 240000 / s;
            if (b > 1023) b = 1023;
            // one cycle before writeback: divider busy, old result still shown
            add_snap(k + 26, M_BUSY | (m_valid ? M_VALID : 0) | m_bpm, M_BUSY | M_VALID | M_BPM, tag);
            wb_q.push_back('{k + 27, b});
            m_bpm = b;
            m_valid = 1'b1;
         end
      end
      m_trk = 1'b1;
   endtask

   // the next impulse lands gap cycles after the previous one; since_ms reads gap-1 then
   task automatic beat(input int g, input int tag);
      beat_iv(g - 1, g - 1, 1'b1, tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample_in = '0;
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      add_snap(cyc + 1, 0, M_ALL, 1);
      model_clear();
   endtask

   // monitor / scoreboard
   initial begin
      bit prev_busy;
      int cur, k;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         cur = int'({onset_pulse, beat_led, busy, bpm_valid, bpm});
         if (onset_pulse) begin
            n_cmp++;
            if (pulse_q.size() > 0 && pulse_q[0] == cyc) void'(pulse_q.pop_front());
            else begin
               n_bad++;
               $display("FAIL pulse: onset_pulse at cycle %0d, next expected at %0d",
                        cyc, pulse_q.size() > 0 ? pulse_q[0] : -1);
            end
         end
         while (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL pulse: no onset_pulse at cycle %0d (got none)", pulse_q[0]);
            void'(pulse_q.pop_front());
         end
         if (prev_busy && !busy && bpm_valid) begin
            n_cmp++;
            if (wb_q.size() == 0) begin
               n_bad++;
               $display("FAIL writeback: unexpected bpm=%0d at cycle %0d, expected none", bpm, cyc);
            end else begin
               if (wb_q[0].cyc != cyc || wb_q[0].bpm != int'(bpm)) begin
                  n_bad++;
                  $display("FAIL writeback: bpm=%0d at cycle %0d, expected bpm=%0d at cycle %0d",
                           bpm, cyc, wb_q[0].bpm, wb_q[0].cyc);
               end
               void'(wb_q.pop_front());
            end
         end
         while (wb_q.size() > 0 && wb_q[0].cyc < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL writeback: none at cycle %0d, expected bpm=%0d", wb_q[0].cyc, wb_q[0].bpm);
            void'(wb_q.pop_front());
         end
         for (int i = snap_q.size() - 1; i >= 0; i--) begin
            if (snap_q[i].cyc <= cyc) begin
               n_cmp++;
               if (snap_q[i].cyc != cyc || (cur & snap_q[i].mask) != snap_q[i].val) begin
                  n_bad++;
                  $display("FAIL snap%0d: cycle %0d got 0x%0h, expected 0x%0h (mask 0x%0h) at cycle %0d",
                           snap_q[i].tag, cyc, cur & snap_q[i].mask, snap_q[i].val,
                           snap_q[i].mask, snap_q[i].cyc);
               end
               snap_q.delete(i);
            end
         end
         prev_busy = busy;
         if (done) begin
            k = pulse_q.size() + wb_q.size() + snap_q.size();
            if (k != 0) begin
               n_cmp++; n_bad++;
               $display("FAIL drain: %0d expectations left, expected 0", k);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end
      end
   end

   // stimulus
   initial begin
      int k;
      do_reset();

      // first impulse only sets the reference; four more intervals fill the history
      gap(5);
      hit(1'b1);
      m_trk = 1'b1;
      repeat (3) beat(500, 2);
      add_snap(cyc + 30, 0, M_VALID, 3);
      beat(500, 4);                                   // 4 x 499 -> 120

      // 400/600 pattern, then 300 replaces the oldest 400
      beat(401, 5); beat(601, 6); beat(401, 7); beat(601, 8);   // sum 2000 -> 120
      beat(301, 9);                                             // sum 1900 -> 126

      // refractory: impulse 100 cycles after a beat is ignored
      beat(500, 10);
      gap(99);
      hit(1'b0);
      add_snap(cyc + 1, 0, M_LED, 11);
      add_snap(cyc + 2, 0, M_LED, 12);
      beat_iv(400, 500, 1'b1, 13);

      // timeout: since_ms hits 2001 at onset+2001, outputs clear the cycle after
      k = cyc;
      add_snap(k + 2002, M_VALID | m_bpm, M_VALID | M_BPM, 14);
      add_snap(k + 2003, 0, M_ALL, 15);
      gap(2100);
      model_clear();
      hit(1'b1);
      m_trk = 1'b1;
      repeat (3) beat(500, 16);
      add_snap(cyc + 30, 0, M_VALID | M_BPM, 17);
      beat(500, 18);

      // interval limits: 2000 and 250 are both accepted
      beat(2001, 19);
      beat(251, 20);

      // reset in the middle of a divide
      beat_iv(499, 499, 1'b0, 21);
      k = cyc;
      add_snap(k + 10, M_BUSY | M_VALID | m_bpm, M_BUSY | M_VALID | M_BPM, 22);
      add_snap(k + 11, 0, M_ALL, 23);
      gap(9);
      @(negedge clk);
      reset = 1'b1;
      sample_in = '0;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      gap(40);
      add_snap(cyc + 1, 0, M_ALL, 24);

      // constant level: one onset, then EMA tracks within the offset
      step(16'd1000, 1'b1);
      k = cyc;
      pulse_q.push_back(k + 1);
      add_snap(k + 100, M_LED, M_LED, 25);
      add_snap(k + 101, 0, M_LED, 26);
      repeat (4999) step(16'd1000, 1'b1);
      gap(10);
      done = 1'b1;
   end
endmodule
